// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared types and helpers for the word serializer
package ser_pkg;

    // IDLE drives the idle level on the line; SHIFT drives bits of the current word.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Number of bits shifted per word: data bits plus an optional parity bit.
    function automatic int total_bits(input int num_bits, input bit parity_en);
        return parity_en ? num_bits + 1 : num_bits;
    endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// rtl/ser_shift_reg.sv - loadable shift register with selectable shift direction
//
// Ports:
//   clk          rising-edge clock
//   load         parallel load of parallel_in (wins over shift_en)
//   shift_en     move contents one place toward the output end
//   parallel_in  WIDTH-bit load value
//   serial_out   bit currently at the output end (MSB if MSB_FIRST, else LSB)
module ser_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             serial_out
);

    logic [WIDTH-1:0] q;

    // Pure datapath: contents only matter after a load, so no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            q <= parallel_in;
        end else if (shift_en) begin
            q <= MSB_FIRST ? (q << 1) : (q >> 1);
        end
    end

    assign serial_out = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - parallel-to-serial feeder with one-word holding buffer
//
// Optional feature: define SER_PARITY_EN to append an even-parity bit after
// each word's data bits.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   data_in       word to serialize
//   data_valid    data_in is valid
//   data_ready    holding register empty (= !hold_full, no path from data_valid)
//   shift_strobe  advance the serial line one bit this cycle
//   serial_out    registered serial bit, IDLE_BIT when idle
//   busy          registered; high while shifting or while a word is held
module word_serializer
    import ser_pkg::*;
#(
    parameter int   NUM_BITS  = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] data_in,
    input  logic                data_valid,
    output logic                data_ready,
    input  logic                shift_strobe,
    output logic                serial_out,
    output logic                busy
);

`ifdef SER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int TB    = total_bits(NUM_BITS, PAR_EN);
    localparam int CNT_W = $clog2(NUM_BITS + 1);

    ser_state_t          state, state_nxt;
    logic [NUM_BITS-1:0] hold_reg;
    logic                hold_full, hold_full_nxt;
    logic [CNT_W-1:0]    bit_cnt;

    logic [TB-1:0]       frame_vec;
    logic [TB-1:0]       rest_vec;
    logic                first_bit;
    logic                sh_head;

    logic                accept, load, advance, finish;

    assign data_ready = !hold_full;
    assign accept     = data_valid && !hold_full;
    // A held word is transferred either from IDLE or on the last bit of the
    // current word, which gives gap-free back-to-back streaming.
    assign load       = shift_strobe && hold_full && ((state == IDLE) || (bit_cnt == '0));
    assign advance    = shift_strobe && (state == SHIFT) && (bit_cnt != '0);
    assign finish     = shift_strobe && (state == SHIFT) && (bit_cnt == '0) && !hold_full;

    // Frame is ordered so the parity bit always leaves last.
    always_comb begin
`ifdef SER_PARITY_EN
        frame_vec = MSB_FIRST ? {hold_reg, ^hold_reg} : {^hold_reg, hold_reg};
`else
        frame_vec = hold_reg;
`endif
        first_bit = MSB_FIRST ? frame_vec[TB-1] : frame_vec[0];
        // The first bit goes straight to serial_out, so the shifter only
        // keeps the remaining bits; its head is always the next bit to send.
        rest_vec  = MSB_FIRST ? (frame_vec << 1) : (frame_vec >> 1);
    end

    ser_shift_reg #(
        .WIDTH    (TB),
        .MSB_FIRST(MSB_FIRST)
    ) u_shift (
        .clk        (clk),
        .load       (load),
        .shift_en   (advance),
        .parallel_in(rest_vec),
        .serial_out (sh_head)
    );

    always_comb begin
        state_nxt     = state;
        hold_full_nxt = hold_full;
        if (load) begin
            state_nxt     = SHIFT;
            hold_full_nxt = 1'b0;
        end else if (finish) begin
            state_nxt = IDLE;
        end
        // accept needs !hold_full and load needs hold_full: never both.
        if (accept) begin
            hold_full_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold_full  <= 1'b0;
            bit_cnt    <= '0;
            serial_out <= IDLE_BIT;
            busy       <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_full <= hold_full_nxt;
            busy      <= (state_nxt == SHIFT) || hold_full_nxt;
            if (accept) begin
                hold_reg <= data_in;
            end
            if (load) begin
                serial_out <= first_bit;
                bit_cnt    <= CNT_W'(TB - 1);
            end else if (advance) begin
                serial_out <= sh_head;
                bit_cnt    <= bit_cnt - CNT_W'(1);
            end else if (finish) begin
                serial_out <= IDLE_BIT;
            end
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// tb/tb_word_serializer.sv - directed self-checking bench for word_serializer
module tb_word_serializer;

`ifdef SER_PARITY_EN
    localparam int TB = 9;
`else
    localparam int TB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       shift_strobe = 1'b0;
    logic       data_ready;
    logic       serial_out;
    logic       busy;

    int vecs = 0;
    int errs = 0;

    bit [2:0] det_hist = 3'b000;
    int       det_hits = 0;

    word_serializer #(
        .NUM_BITS (8),
        .MSB_FIRST(1'b1),
        .IDLE_BIT (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .shift_strobe(shift_strobe),
        .serial_out  (serial_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // '1101' detector watching the serial line every clock.
    always @(posedge clk) begin
        det_hist <= {det_hist[1:0], serial_out};
        if ({det_hist, serial_out} == 4'b1101) det_hits <= det_hits + 1;
    end

    // Word followed by its even-parity bit; bit 8-i is the i-th bit sent.
    function automatic logic [8:0] frame(input logic [7:0] w);
        return {w, ^w};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; data_valid = 1'b0; shift_strobe = 1'b1;
        tick; tick;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            vecs++; if (serial_out !== 1'b0) begin errs++; $display("FAIL reset_serial cyc %0d: got %b want 0", i, serial_out); end
            vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy cyc %0d: got %b want 0", i, busy); end
            vecs++; if (data_ready !== 1'b1) begin errs++; $display("FAIL reset_ready cyc %0d: got %b want 1", i, data_ready); end
        end
    endtask

    task automatic test_single_word;
        logic [8:0] exp;
        int hits0;
        hits0 = det_hits;
        exp = frame(8'hD0);
        data_in = 8'hD0; data_valid = 1'b1; shift_strobe = 1'b1;
        tick;
        data_valid = 1'b0;
        vecs++; if (data_ready !== 1'b0) begin errs++; $display("FAIL single_ready_e0: got %b want 0", data_ready); end
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL single_busy_e0: got %b want 1", busy); end
        vecs++; if (serial_out !== 1'b0) begin errs++; $display("FAIL single_serial_e0: got %b want 0", serial_out); end
        for (int i = 0; i < TB; i++) begin
            tick;
            vecs++; if (serial_out !== exp[8-i]) begin errs++; $display("FAIL single_bit %0d: got %b want %b", i, serial_out, exp[8-i]); end
        end
        tick;
        vecs++; if (serial_out !== 1'b0) begin errs++; $display("FAIL single_idle: got %b want 0", serial_out); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL single_busy_end: got %b want 0", busy); end
        vecs++; if (data_ready !== 1'b1) begin errs++; $display("FAIL single_ready_end: got %b want 1", data_ready); end
        tick; tick; tick;
        vecs++; if (det_hits - hits0 !== 1) begin errs++; $display("FAIL single_detect: got %0d hits want 1", det_hits - hits0); end
    endtask

    task automatic test_back_to_back;
        logic [17:0] seq;
        int n;
`ifdef SER_PARITY_EN
        seq = {frame(8'hB5), frame(8'h0D)};
        n = 18;
`else
        seq = {2'b00, 8'hB5, 8'h0D};
        n = 16;
`endif
        data_in = 8'hB5; data_valid = 1'b1; shift_strobe = 1'b1;
        tick;
        data_in = 8'h0D;
        for (int i = 0; i < n; i++) begin
            tick;
            vecs++; if (serial_out !== seq[n-1-i]) begin errs++; $display("FAIL b2b_bit %0d: got %b want %b", i, serial_out, seq[n-1-i]); end
            if (i == 1) begin
                data_valid = 1'b0;
                vecs++; if (data_ready !== 1'b0) begin errs++; $display("FAIL b2b_second_held: ready got %b want 0", data_ready); end
            end
        end
        tick;
        vecs++; if (serial_out !== 1'b0) begin errs++; $display("FAIL b2b_idle: got %b want 0", serial_out); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_sparse_strobe;
        logic [8:0] exp;
        exp = frame(8'hA5);
        shift_strobe = 1'b0; data_in = 8'hA5; data_valid = 1'b1;
        tick;
        data_valid = 1'b0;
        vecs++; if (serial_out !== 1'b0) begin errs++; $display("FAIL sparse_wait: got %b want 0", serial_out); end
        for (int k = 0; k < 3 * TB; k++) begin
            shift_strobe = (k % 3 == 0);
            tick;
            vecs++; if (serial_out !== exp[8 - k/3]) begin errs++; $display("FAIL sparse_cyc %0d: got %b want %b", k, serial_out, exp[8 - k/3]); end
        end
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL sparse_busy_mid: got %b want 1", busy); end
        shift_strobe = 1'b1;
        tick;
        vecs++; if (serial_out !== 1'b0) begin errs++; $display("FAIL sparse_idle: got %b want 0", serial_out); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL sparse_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid;
        data_in = 8'hFF; data_valid = 1'b1; shift_strobe = 1'b1;
        tick;
        data_in = 8'h3C;
        tick;
        tick;
        data_valid = 1'b0;
        tick; tick;
        vecs++; if (serial_out !== 1'b1) begin errs++; $display("FAIL rstmid_bit4: got %b want 1", serial_out); end
        vecs++; if (data_ready !== 1'b0) begin errs++; $display("FAIL rstmid_held: ready got %b want 0", data_ready); end
        rst = 1'b1;
        tick;
        vecs++; if (serial_out !== 1'b0) begin errs++; $display("FAIL rstmid_serial: got %b want 0", serial_out); end
        vecs++; if (data_ready !== 1'b1) begin errs++; $display("FAIL rstmid_ready: got %b want 1", data_ready); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            vecs++; if (serial_out !== 1'b0) begin errs++; $display("FAIL rstmid_resume cyc %0d: got %b want 0", i, serial_out); end
            vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy cyc %0d: got %b want 0", i, busy); end
        end
    endtask

`ifdef SER_PARITY_EN
    task automatic test_parity;
        logic [8:0] exp;
        exp = 9'b0000_0111_1;
        data_in = 8'h07; data_valid = 1'b1; shift_strobe = 1'b1;
        tick;
        data_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick;
            vecs++; if (serial_out !== exp[8-i]) begin errs++; $display("FAIL parity_bit %0d: got %b want %b", i, serial_out, exp[8-i]); end
        end
        tick;
        vecs++; if (serial_out !== 1'b0) begin errs++; $display("FAIL parity_idle: got %b want 0", serial_out); end
    endtask
`endif

    initial begin
        test_reset;
        test_single_word;
        test_back_to_back;
        test_sparse_strobe;
        test_reset_mid;
`ifdef SER_PARITY_EN
        test_parity;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
